mem32_arbiter: RTL

MEM32_ARBITER -- requirements
Module: mem32_arbiter

---
 rtl/mem32_arbiter_if.sv | 31 +++
 rtl/mem32_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem32_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a 32-byte memory.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface mem32_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [4:0] addr0;
    logic [4:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem32_arbiter.sv
// Round-robin arbiter granting two requesters single-byte access to a 32-byte memory.
// Each transaction walks IDLE -> ACCESS -> DONE; every output is a register.

module mem32_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic mem_read,
    input logic mem_write,
    input logic ack0,
    input logic ack1
);
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
    a_acks_exclusive:    assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
endmodule

module mem32_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input logic            clk,
    input logic            reset,
    mem32_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic PRIO_RST = (PRIO_INIT != 0) ? 1'b1 : 1'b0;

    state_t     state_r, state_s;
    logic       prio_r, gnt_r;
    logic       grant_s, gnt_s, we_s;
    logic [4:0] addr_s;
    logic [7:0] wdata_s;
    logic       rd_s, wr_s, ack0_s, ack1_s;
    logic       rd_r, wr_r, ack0_r, ack1_r, busy_r;
    logic [7:0] rdata_r;
    logic [4:0] maddr_r;
    logic [7:0] mwdata_r;

    // Next state, arbitration decision and next values of the registered strobes
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        gnt_s   = gnt_r;
        we_s    = 1'b0;
        addr_s  = maddr_r;
        wdata_s = mwdata_r;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        ack0_s  = 1'b0;
        ack1_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_s = 1'b1;
                    // Contention goes to the pointer holder; a lone request wins outright
                    if (bus.req0 && bus.req1) begin
                        gnt_s = prio_r;
                    end else begin
                        gnt_s = bus.req1;
                    end
                    if (gnt_s) begin
                        we_s    = bus.we1;
                        addr_s  = bus.addr1;
                        wdata_s = bus.wdata1;
                    end else begin
                        we_s    = bus.we0;
                        addr_s  = bus.addr0;
                        wdata_s = bus.wdata0;
                    end
                    rd_s    = ~we_s;
                    wr_s    = we_s;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                state_s = DONE;
                ack0_s  = ~gnt_r;
                ack1_s  = gnt_r;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant bookkeeping, memory-side registers and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_r   <= PRIO_RST;
            gnt_r    <= 1'b0;
            maddr_r  <= 5'd0;
            mwdata_r <= 8'h00;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            busy_r   <= 1'b0;
            rdata_r  <= 8'h00;
        end else begin
            if (grant_s) begin
                prio_r <= ~gnt_s;
            end else begin
                prio_r <= prio_r;
            end
            gnt_r    <= gnt_s;
            maddr_r  <= addr_s;
            mwdata_r <= wdata_s;
            rd_r     <= rd_s;
            wr_r     <= wr_s;
            ack0_r   <= ack0_s;
            ack1_r   <= ack1_s;
            busy_r   <= (state_s != IDLE);
            // The read strobe is only high during ACCESS, so this is the ACCESS edge
            if (rd_r) begin
                rdata_r <= bus.mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.rdata     = rdata_r;
    assign bus.busy      = busy_r;
    assign bus.mem_addr  = maddr_r;
    assign bus.mem_wdata = mwdata_r;
    assign bus.mem_read  = rd_r;
    assign bus.mem_write = wr_r;
endmodule
